// File: rtl/qspi_psram_target.sv
// QSPI PSRAM target model: 0xEB quad read with dummy cycles, 0x38 quad write, backdoor byte port.
// All QSPI pins are oversampled through 2-flop synchronizers on the system clock.
module qspi_psram_target #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 psram_sck,
  input  logic                 psram_ce_n,
  input  logic [3:0]           psram_din,
  output logic [3:0]           psram_dout,
  output logic [3:0]           psram_douten,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata,
  output logic                 busy
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StRdData, StWrData, StIgnore} state_t;

  state_t         state;
  logic           sck_s1, sck_s2, sck_q;
  logic           ce_s1, ce_s2;
  logic [3:0]     din_s1, din_s2;
  logic [1:0]     settle;
  logic           armed;
  logic [7:0]     cnt;
  logic           nib;
  logic [7:0]     cmd;
  logic [23:0]    addr;
  logic [3:0]     wbuf;
  logic [7:0]     mem [Depth];

  logic                 sck_rise, sck_fall, q_we;
  logic [ADDR_BITS-1:0] addr_lo, addr_inc;
  logic [7:0]           cmd_next, rd_byte;

  always_comb begin
    sck_rise = sck_s2 & ~sck_q;
    sck_fall = ~sck_s2 & sck_q;
    addr_lo  = addr[ADDR_BITS-1:0];
    addr_inc = addr_lo + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    cmd_next = {cmd[6:0], din_s2[0]};
    rd_byte  = mem[addr_lo];
    // A rising ce_n discards the pending low nibble, so the write is gated on ce_s2.
    q_we     = !rst && !ce_s2 && state == StWrData && sck_rise && nib;
    busy     = state != StIdle;
  end

  // Backdoor first, QSPI second: on an address collision the QSPI byte lands last.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
    if (q_we)  mem[addr_lo] <= {wbuf, din_s2};
  end

  always_ff @(posedge clk) begin
    if (rst) bd_rdata <= 8'h00;
    else     bd_rdata <= mem[bd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      sck_s1       <= 1'b0;
      sck_s2       <= 1'b0;
      sck_q        <= 1'b0;
      ce_s1        <= 1'b1;
      ce_s2        <= 1'b1;
      din_s1       <= 4'h0;
      din_s2       <= 4'h0;
      settle       <= 2'd0;
      armed        <= 1'b0;
      cnt          <= 8'd0;
      nib          <= 1'b0;
      cmd          <= 8'h00;
      addr         <= 24'h0;
      wbuf         <= 4'h0;
      psram_dout   <= 4'h0;
      psram_douten <= 4'h0;
    end else begin
      sck_s1 <= psram_sck;
      sck_s2 <= sck_s1;
      sck_q  <= sck_s2;
      ce_s1  <= psram_ce_n;
      ce_s2  <= ce_s1;
      din_s1 <= psram_din;
      din_s2 <= din_s1;
      // After reset the synchronizer needs two clocks before ce_s2 shows the real pin; only
      // then can a genuine ce_n high re-arm the block, so a held-low ce_n is not a new start.
      if (settle != 2'd2) settle <= settle + 2'd1;
      else if (ce_s2)     armed  <= 1'b1;

      if (ce_s2) begin
        state        <= StIdle;
        cnt          <= 8'd0;
        nib          <= 1'b0;
        psram_dout   <= 4'h0;
        psram_douten <= 4'h0;
      end else begin
        unique case (state)
          StIdle: begin
            if (armed) begin
              state <= StCmd;
              cnt   <= 8'd0;
              nib   <= 1'b0;
            end
          end
          StCmd: begin
            if (sck_rise) begin
              cmd <= cmd_next;
              cnt <= cnt + 8'd1;
              if (cnt == 8'd7) begin
                cnt   <= 8'd0;
                state <= (cmd_next == 8'hEB || cmd_next == 8'h38) ? StAddr : StIgnore;
              end
            end
          end
          StAddr: begin
            if (sck_rise) begin
              addr <= {addr[19:0], din_s2};
              cnt  <= cnt + 8'd1;
              if (cnt == 8'd5) begin
                cnt <= 8'd0;
                nib <= 1'b0;
                if (cmd == 8'h38)          state <= StWrData;
                else if (WAIT_STATES == 0) state <= StRdData;
                else                       state <= StDummy;
              end
            end
          end
          StDummy: begin
            if (sck_rise) begin
              cnt <= cnt + 8'd1;
              if (32'(cnt) == WAIT_STATES - 1) begin
                cnt   <= 8'd0;
                nib   <= 1'b0;
                state <= StRdData;
              end
            end
          end
          StRdData: begin
            if (sck_fall) begin
              psram_douten <= 4'hF;
              nib          <= ~nib;
              if (!nib) begin
                psram_dout <= rd_byte[7:4];
              end else begin
                psram_dout            <= rd_byte[3:0];
                addr[ADDR_BITS-1:0]   <= addr_inc;
              end
            end
          end
          StWrData: begin
            if (sck_rise) begin
              nib <= ~nib;
              if (!nib) wbuf <= din_s2;
              else      addr[ADDR_BITS-1:0] <= addr_inc;
            end
          end
          StIgnore: state <= StIgnore;
          default:  state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_psram_target.sv
// Bench for qspi_psram_target: directed scenarios plus randomized reads/writes against a byte-array model.
module tb_qspi_psram_target;

  localparam int Half = 5;  // sck half-period in clk cycles
  localparam int Ws   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psram_sck = 1'b0;
  logic       psram_ce_n = 1'b1;
  logic [3:0] psram_din = 4'h0;
  logic [3:0] psram_dout, psram_douten;
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_wdata = 8'h00;
  logic [7:0] bd_rdata;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model_mem [256];
  logic [7:0] wq [$];

  qspi_psram_target #(.ADDR_BITS(8), .WAIT_STATES(Ws)) dut (
    .clk(clk), .rst(rst), .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
    .psram_din(psram_din), .psram_dout(psram_dout), .psram_douten(psram_douten),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sck_cycle(input logic [3:0] d, output logic [3:0] q, output logic [3:0] en);
    psram_din = d;
    repeat (Half) @(negedge clk);
    q  = psram_dout;
    en = psram_douten;
    psram_sck = 1'b1;
    repeat (Half) @(negedge clk);
    psram_sck = 1'b0;
  endtask

  task automatic ce_low();
    psram_ce_n = 1'b0;
    repeat (Half) @(negedge clk);
  endtask

  task automatic ce_high();
    repeat (Half) @(negedge clk);
    psram_ce_n = 1'b1;
    repeat (2 * Half) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    logic [3:0] q, en;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, q, en);
  endtask

  task automatic send_addr(input logic [7:0] a);
    logic [23:0] a24;
    logic [3:0]  q, en;
    a24 = {16'h0000, a};
    for (int i = 5; i >= 0; i--) sck_cycle(a24[i*4 +: 4], q, en);
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we    = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bd_check(input string tag, input logic [7:0] a);
    bd_addr = a;
    @(negedge clk);
    check(tag, {24'h0, bd_rdata}, {24'h0, model_mem[a]});
  endtask

  // Full 0xEB read of n bytes; every returned nibble is compared with the model.
  task automatic qspi_read(input string tag, input logic [7:0] a, input int n);
    logic [3:0] q, en;
    logic [7:0] ea;
    ce_low();
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < Ws; i++) begin
      sck_cycle(4'h0, q, en);
      if (i == 0 || i == Ws - 1) check({tag, "_dummy_oe"}, {28'h0, en}, 32'h0);
    end
    ea = a;
    for (int i = 0; i < n; i++) begin
      sck_cycle(4'h0, q, en);
      check({tag, "_hi"}, {28'h0, q}, {28'h0, model_mem[ea][7:4]});
      check({tag, "_oe"}, {28'h0, en}, 32'hF);
      sck_cycle(4'h0, q, en);
      check({tag, "_lo"}, {28'h0, q}, {28'h0, model_mem[ea][3:0]});
      ea = ea + 8'd1;
    end
    ce_high();
  endtask

  task automatic qspi_write(input logic [7:0] a);
    logic [3:0] q, en;
    logic [7:0] ea;
    ce_low();
    send_cmd(8'h38);
    send_addr(a);
    ea = a;
    foreach (wq[i]) begin
      sck_cycle(wq[i][7:4], q, en);
      sck_cycle(wq[i][3:0], q, en);
      model_mem[ea] = wq[i];
      ea = ea + 8'd1;
    end
    ce_high();
  endtask

  // Backdoor strobe placed on the clk where the final write nibble's sck rise is acted on
  // (two synchronizer flops, then the edge is seen and the byte written on the next clk).
  task automatic collide(input logic [7:0] qa, input logic [7:0] qd,
                         input logic [7:0] ba, input logic [7:0] bdv);
    logic [3:0] q, en;
    ce_low();
    send_cmd(8'h38);
    send_addr(qa);
    sck_cycle(qd[7:4], q, en);
    psram_din = qd[3:0];
    repeat (Half) @(negedge clk);
    psram_sck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bd_addr  = ba;
    bd_wdata = bdv;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we    = 1'b0;
    repeat (Half - 3) @(negedge clk);
    psram_sck = 1'b0;
    ce_high();
    model_mem[ba] = bdv;
    model_mem[qa] = qd;
  endtask

  initial begin
    logic [3:0] q, en;
    logic [7:0] a;
    int         n;

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_oe", {28'h0, psram_douten}, 32'h0);
    check("rst_dout", {28'h0, psram_dout}, 32'h0);
    check("rst_bd_rdata", {24'h0, bd_rdata}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom_range(0, 255)));

    // Directed read of a preloaded pair
    bd_write(8'h10, 8'hA5);
    bd_write(8'h11, 8'h3C);
    qspi_read("rd_a53c", 8'h10, 2);

    // Write crossing the top of the array
    wq = '{8'h11, 8'h22, 8'h33};
    qspi_write(8'hFE);
    bd_check("wr_fe", 8'hFE);
    bd_check("wr_ff", 8'hFF);
    bd_check("wr_wrap_00", 8'h00);

    // Unsupported command is ignored
    ce_low();
    send_cmd(8'h9F);
    for (int i = 0; i < 24; i++) begin
      sck_cycle(4'($urandom_range(0, 15)), q, en);
      if (i % 8 == 7) check("ign_oe", {28'h0, en}, 32'h0);
    end
    check("ign_busy", {31'h0, busy}, 32'h1);
    ce_high();
    check("ign_idle", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 4; i++) bd_check("ign_mem", 8'($urandom_range(0, 255)));

    // One byte plus a stray nibble: only the full byte lands
    ce_low();
    send_cmd(8'h38);
    send_addr(8'h40);
    sck_cycle(4'h9, q, en);
    sck_cycle(4'h6, q, en);
    sck_cycle(4'h7, q, en);
    model_mem[8'h40] = 8'h96;
    ce_high();
    check("part_busy", {31'h0, busy}, 32'h0);
    bd_check("part_byte", 8'h40);
    bd_check("part_next", 8'h41);

    // Reset in the middle of a read
    ce_low();
    send_cmd(8'hEB);
    send_addr(8'h10);
    for (int i = 0; i < Ws; i++) sck_cycle(4'h0, q, en);
    sck_cycle(4'h0, q, en);
    check("rrst_pre_hi", {28'h0, q}, 32'hA);
    check("rrst_pre_oe", {28'h0, en}, 32'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rrst_oe_now", {28'h0, psram_douten}, 32'h0);
    for (int i = 0; i < 8; i++) sck_cycle(4'hB, q, en);
    check("rrst_oe_held", {28'h0, en}, 32'h0);
    check("rrst_busy", {31'h0, busy}, 32'h0);
    ce_high();
    qspi_read("rrst_after", 8'h10, 2);

    // Backdoor vs QSPI write collisions
    collide(8'h20, 8'h5A, 8'h20, 8'hC3);
    bd_check("coll_same", 8'h20);
    collide(8'h20, 8'h77, 8'h21, 8'h88);
    bd_check("coll_q", 8'h20);
    bd_check("coll_bd", 8'h21);

    // Randomized mix against the model
    for (int it = 0; it < 10; it++) begin
      a = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        wq = {};
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
        qspi_write(a);
        bd_check("rnd_wr", a);
      end else begin
        qspi_read("rnd_rd", a, n);
      end
    end
    for (int i = 0; i < 8; i++) bd_check("rnd_final", 8'($urandom_range(0, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_psram_target.md
QSPI_PSRAM_TARGET -- requirements
Module: qspi_psram_target

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, setting the internal array depth to 2^ADDR_BITS bytes.
REQ-002 The block SHALL have parameter WAIT_STATES, default 8, giving the dummy sck cycles between address and read data for command 0xEB.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port psram_sck, input, 1, the QSPI serial clock from the controller, at most clk/4.
REQ-006 The block SHALL have port psram_ce_n, input, 1, the active-low chip enable.
REQ-007 The block SHALL have port psram_din, input, 4, the data lines as seen by the target.
REQ-008 The block SHALL have port psram_dout, output, 4, the read data nibble.
REQ-009 The block SHALL have port psram_douten, output, 4, the per-line output enables, active-high.
REQ-010 The block SHALL have port bd_we, input, 1, the backdoor byte-write strobe.
REQ-011 The block SHALL have port bd_addr, input, ADDR_BITS, the backdoor address.
REQ-012 The block SHALL have port bd_wdata, input, 8, the backdoor write data.
REQ-013 The block SHALL have port bd_rdata, output, 8, the backdoor read data, registered, equal to mem[bd_addr] one clk later.
REQ-014 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 The block SHALL pass psram_sck, psram_ce_n and psram_din through 2-flop synchronizers and detect sck rise and fall from the synchronized copies.
REQ-016 The states SHALL be IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA and IGNORE.
REQ-017 IDLE SHALL go to CMD when synchronized ce_n goes low; the bit and nibble counters SHALL clear.
REQ-018 CMD SHALL shift din[0] MSB-first on 8 sck rises, then go to ADDR for 0xEB or 0x38 and to IGNORE for any other byte.
REQ-019 ADDR SHALL shift a 24-bit address as 6 nibbles (din[3:0], MSB nibble first) on sck rises; only bits [ADDR_BITS-1:0] are used.
REQ-020 After ADDR, command 0xEB SHALL go to DUMMY and 0x38 SHALL go to WR_DATA.
REQ-021 DUMMY SHALL count WAIT_STATES sck rises, then go to RD_DATA.
REQ-022 In DUMMY with WAIT_STATES=0, the block SHALL go directly from ADDR to RD_DATA.
REQ-023 RD_DATA SHALL drive mem[addr][7:4] on the first sck fall, then mem[addr][3:0] on the next fall, then increment addr.
REQ-024 psram_douten SHALL be 4'hF from the first RD_DATA sck fall until ce_n deasserts, and 4'h0 at all other times.
REQ-025 WR_DATA SHALL sample the high nibble, then the low nibble, on sck rises, write the byte on the second rise, then increment addr.
REQ-026 addr SHALL wrap from 2^ADDR_BITS-1 to 0 in both RD_DATA and WR_DATA.
REQ-027 IGNORE SHALL hold outputs idle and ignore sck until ce_n deasserts.
REQ-028 A synchronized ce_n high in any state SHALL force IDLE within 1 clk, set douten to 0, and discard any partial write nibble.
REQ-029 On a bd_we and QSPI byte write to the same address in the same clk, the QSPI write SHALL win; different addresses SHALL both complete.
REQ-030 bd_rdata SHALL reflect any write completed in the previous clk.

Reset
REQ-031 While rst is high at a clk edge, the block SHALL force state IDLE, psram_dout 4'h0, psram_douten 4'h0, busy 0, bd_rdata 8'h00, and clear all counters and synchronizers (ce_n synchronizer to 1).
REQ-032 Array contents SHALL NOT be reset.
REQ-033 A reset mid-transaction SHALL abort it; the block SHALL need a fresh ce_n fall before responding again.

Verification
REQ-034 Preload bd mem[0x10]=0xA5, 0x11=0x3C; QSPI read 0xEB addr 0x000010, WAIT_STATES=8, 4 data nibbles -> controller samples A,5,3,C; douten 0 through dummy.
REQ-035 QSPI write 0x38 addr 0x0000FE, data 0x11,0x22,0x33 -> bd reads 0xFE=0x11, 0xFF=0x22, 0x00=0x33 (wrap).
REQ-036 Command 0x9F, then 24 sck -> douten stays 0, memory unchanged, busy high until ce_n rises.
REQ-037 A write of one byte plus one nibble, then ce_n raised -> only the first byte is written; state IDLE; busy 0.
REQ-038 rst pulsed during RD_DATA -> douten 0 next clk, sck ignored until ce_n high then low; next 0xEB read returns correct data.
REQ-039 bd_we to 0x20 coincident with QSPI byte write to 0x20 -> QSPI data retained; same with 0x21 vs 0x20 -> both written.
